f1_reaction_timer: RTL

F1_REACTION_TIMER -- requirements
Module: f1_reaction_timer

---
 rtl/f1_reaction_timer.sv | 104 ++++++++++
 1 files changed

// File: rtl/f1_reaction_timer.sv
// f1_reaction_timer: F1 start-light reaction timer measuring lights-out to button press in clk cycles.
// Define F1_SEQ_CHECK_EN to fault on illegal start-light sequences (otherwise they are ignored).
module f1_reaction_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       lights,
  input  logic             btn,
  input  logic             clr,
  output logic [CNT_W-1:0] time_out,
  output logic             time_valid,
  output logic             jump_start,
  output logic             seq_err,
  output logic             busy
);
  typedef enum logic [2:0] {IDLE, ARMING, ALL_ON, TIMING, DONE, FAULT} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_t state, state_nxt;
  logic [7:0] level, level_nxt, level_up;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc, time_nxt;
  logic btn_q, jump, jump_nxt, press, bad;
  assign press = btn & ~btn_q;
  assign level_up = {level[6:0], 1'b1};
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
`ifdef F1_SEQ_CHECK_EN
  assign bad = lights != level && lights != level_up && lights != 8'hff &&
               !(state == ALL_ON && lights == 8'h00);
`else
  assign bad = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    level_nxt = level;
    cnt_nxt = cnt;
    time_nxt = time_out;
    jump_nxt = jump;
    case (state)
      IDLE: begin
        if (lights == 8'h01) begin
          state_nxt = ARMING;
          level_nxt = 8'h01;
        end
      end
      ARMING: begin
        if (press || bad) begin
          state_nxt = FAULT;
          jump_nxt = press;
        end else if (lights == level_up) begin
          level_nxt = level_up;
          state_nxt = (level_up == 8'hff) ? ALL_ON : ARMING;
        end
      end
      ALL_ON: begin
        if (press || bad) begin
          state_nxt = FAULT;
          jump_nxt = press;
        end else if (lights == 8'h00) begin
          state_nxt = TIMING;
          cnt_nxt = '0;
        end
      end
      TIMING: begin
        // the press cycle itself counts, so a press N cycles after entry reports N
        cnt_nxt = cnt_inc;
        if (press) begin
          state_nxt = DONE;
          time_nxt = cnt_inc;
        end
      end
      default: ;
    endcase
    if (clr) state_nxt = IDLE;
    if (state_nxt == IDLE) begin
      time_nxt = '0;
      cnt_nxt = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      level <= '0;
      cnt <= '0;
      time_out <= '0;
      btn_q <= 1'b0;
      jump <= 1'b0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
      cnt <= cnt_nxt;
      time_out <= time_nxt;
      btn_q <= btn;
      jump <= jump_nxt;
    end
  end
  assign time_valid = state == DONE;
  assign jump_start = state == FAULT && jump;
`ifdef F1_SEQ_CHECK_EN
  assign seq_err = state == FAULT && !jump;
`else
  assign seq_err = 1'b0;
`endif
  assign busy = state == ARMING || state == ALL_ON || state == TIMING;
endmodule
